// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode constants, control group widths and per-opcode control encodings
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam int WB_W = 2;
  localparam int M_W  = 3;
  localparam int EX_W = 4;

  // wb = {RegWrite, MemtoReg}, m = {Branch, MemRead, MemWrite}, ex = {RegDst, ALUOp[1:0], ALUSrc}
  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [EX_W-1:0] ex;
  } ctrl_t;

  localparam ctrl_t CTRL_RTYPE  = '{wb: 2'b10, m: 3'b000, ex: 4'b1100};
  localparam ctrl_t CTRL_LW     = '{wb: 2'b11, m: 3'b010, ex: 4'b0001};
  localparam ctrl_t CTRL_SW     = '{wb: 2'b00, m: 3'b001, ex: 4'b0001};
  localparam ctrl_t CTRL_BEQ    = '{wb: 2'b00, m: 3'b100, ex: 4'b0010};
  localparam ctrl_t CTRL_BUBBLE = '{wb: 2'b00, m: 3'b000, ex: 4'b0000};

  function automatic ctrl_t decode_op(input logic [5:0] op);
    case (op)
      OP_RTYPE: decode_op = CTRL_RTYPE;
      OP_LW:    decode_op = CTRL_LW;
      OP_SW:    decode_op = CTRL_SW;
      OP_BEQ:   decode_op = CTRL_BEQ;
      default:  decode_op = CTRL_BUBBLE;
    endcase
  endfunction

endpackage

// File: rtl/i_decode_if.sv
// rtl/i_decode_if.sv - IF/ID inputs, MEM/WB write-back and ID/EX latch outputs of the decode stage
interface i_decode_if #(
  parameter int WIDTH = 32,
  parameter int REGS  = 32
);
  import mips_pkg::*;

  localparam int AW = $clog2(REGS);

  logic [31:0]      IF_ID_instr;
  logic [WIDTH-1:0] IF_ID_npc;
  logic             MEM_WB_RegWrite;
  logic [AW-1:0]    MEM_WB_WriteReg;
  logic [WIDTH-1:0] MEM_WB_WriteData;

  logic [WIDTH-1:0] ID_EX_npc;
  logic [WIDTH-1:0] ID_EX_readdat1;
  logic [WIDTH-1:0] ID_EX_readdat2;
  logic [WIDTH-1:0] ID_EX_sign_ext;
  logic [AW-1:0]    ID_EX_instr_2016;
  logic [AW-1:0]    ID_EX_instr_1511;
  logic [WB_W-1:0]  ID_EX_wb;
  logic [M_W-1:0]   ID_EX_m;
  logic [EX_W-1:0]  ID_EX_ex;

  modport master (
    output IF_ID_instr, IF_ID_npc, MEM_WB_RegWrite, MEM_WB_WriteReg, MEM_WB_WriteData,
    input  ID_EX_npc, ID_EX_readdat1, ID_EX_readdat2, ID_EX_sign_ext,
           ID_EX_instr_2016, ID_EX_instr_1511, ID_EX_wb, ID_EX_m, ID_EX_ex
  );

  modport slave (
    input  IF_ID_instr, IF_ID_npc, MEM_WB_RegWrite, MEM_WB_WriteReg, MEM_WB_WriteData,
    output ID_EX_npc, ID_EX_readdat1, ID_EX_readdat2, ID_EX_sign_ext,
           ID_EX_instr_2016, ID_EX_instr_1511, ID_EX_wb, ID_EX_m, ID_EX_ex
  );

endinterface

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 2R/1W register file, async reads, sync write and clear, register 0 reads zero
module reg_file #(
  parameter int WIDTH = 32,
  parameter int REGS  = 32,
  parameter int AW    = $clog2(REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd
);

  logic [WIDTH-1:0] regs [REGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/i_decode.sv
// rtl/i_decode.sv - MIPS ID stage: control decode, register read, sign-extend into ID/EX; WB_BYPASS_EN selects write-first reads
module i_decode #(
  parameter int WIDTH = 32,
  parameter int REGS  = 32
) (
  input logic       clk,
  input logic       rst_n,
  i_decode_if.slave bus
);
  import mips_pkg::*;

  localparam int AW = $clog2(REGS);

  logic [AW-1:0]    rs, rt, rd;
  logic [WIDTH-1:0] rf_rd1, rf_rd2, rd1_sel, rd2_sel;
  ctrl_t            ctrl;

  assign rs   = bus.IF_ID_instr[25:21];
  assign rt   = bus.IF_ID_instr[20:16];
  assign rd   = bus.IF_ID_instr[15:11];
  assign ctrl = decode_op(bus.IF_ID_instr[31:26]);

  reg_file #(.WIDTH(WIDTH), .REGS(REGS)) u_reg_file (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (rs),
    .ra2   (rt),
    .rd1   (rf_rd1),
    .rd2   (rf_rd2),
    .we    (bus.MEM_WB_RegWrite),
    .wa    (bus.MEM_WB_WriteReg),
    .wd    (bus.MEM_WB_WriteData)
  );

`ifdef WB_BYPASS_EN
  // Forward the write landing at this edge so the latch never captures a stale value
  logic wb_live;
  assign wb_live = bus.MEM_WB_RegWrite && (bus.MEM_WB_WriteReg != '0);
  assign rd1_sel = (wb_live && bus.MEM_WB_WriteReg == rs) ? bus.MEM_WB_WriteData : rf_rd1;
  assign rd2_sel = (wb_live && bus.MEM_WB_WriteReg == rt) ? bus.MEM_WB_WriteData : rf_rd2;
`else
  assign rd1_sel = rf_rd1;
  assign rd2_sel = rf_rd2;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.ID_EX_npc        <= '0;
      bus.ID_EX_readdat1   <= '0;
      bus.ID_EX_readdat2   <= '0;
      bus.ID_EX_sign_ext   <= '0;
      bus.ID_EX_instr_2016 <= '0;
      bus.ID_EX_instr_1511 <= '0;
      bus.ID_EX_wb         <= '0;
      bus.ID_EX_m          <= '0;
      bus.ID_EX_ex         <= '0;
    end else begin
      bus.ID_EX_npc        <= bus.IF_ID_npc;
      bus.ID_EX_readdat1   <= rd1_sel;
      bus.ID_EX_readdat2   <= rd2_sel;
      bus.ID_EX_sign_ext   <= {{(WIDTH-16){bus.IF_ID_instr[15]}}, bus.IF_ID_instr[15:0]};
      bus.ID_EX_instr_2016 <= rt;
      bus.ID_EX_instr_1511 <= rd;
      bus.ID_EX_wb         <= ctrl.wb;
      bus.ID_EX_m          <= ctrl.m;
      bus.ID_EX_ex         <= ctrl.ex;
    end
  end

endmodule

// File: doc/i_decode.md
# i_decode

Instruction-decode stage of the five-stage MIPS pipeline. It consumes the IF/ID latch outputs produced by the fetch stage, decodes the opcode into WB/M/EX control groups, reads two source registers from an internal 32×32 register file, and sign-extends the immediate. All results are registered into the ID/EX pipeline latch. The MEM/WB stage writes back into the same register file through this block.

## Interface

Parameters:
- `WIDTH`, 32: datapath width.
- `REGS`, 32: register count. Address width is log2(REGS) = 5.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `IF_ID_instr` in 32: instruction from the fetch latch.
- `IF_ID_npc` in 32: PC+1 from the fetch latch.
- `MEM_WB_RegWrite` in 1: write-back enable.
- `MEM_WB_WriteReg` in 5: write-back destination register.
- `MEM_WB_WriteData` in 32: write-back data.
- `ID_EX_npc` out 32: registered copy of `IF_ID_npc`.
- `ID_EX_readdat1` out 32: registered value of rs, from bits [25:21].
- `ID_EX_readdat2` out 32: registered value of rt, from bits [20:16].
- `ID_EX_sign_ext` out 32: registered sign extension of bits [15:0].
- `ID_EX_instr_2016` out 5: registered rt field.
- `ID_EX_instr_1511` out 5: registered rd field.
- `ID_EX_wb` out 2: {RegWrite, MemtoReg}.
- `ID_EX_m` out 3: {Branch, MemRead, MemWrite}.
- `ID_EX_ex` out 4: {RegDst, ALUOp[1:0], ALUSrc}.

## Operation

Control decode is combinational on `IF_ID_instr[31:26]` and registered into the ID/EX latch:
- 0x00 (R-type): ex=1100, m=000, wb=10.
- 0x23 (lw): ex=0001, m=010, wb=11.
- 0x2B (sw): ex=0001, m=001, wb=00.
- 0x04 (beq): ex=0010, m=100, wb=00.
- Any other opcode: all control groups 0. This is a bubble, with no register write or memory access.

Register file:
- Read ports are asynchronous, indexed by rs and rt.
- Register 0 always reads 0.
- Write occurs on the rising edge when `MEM_WB_RegWrite`=1 and `MEM_WB_WriteReg`≠0.
- A write to register 0 is silently dropped.

Sign extension: `ID_EX_sign_ext` = {16{instr[15]}, instr[15:0]}.

Reset (`rst_n`=0 sampled at an edge):
- All ID/EX outputs are 0.
- All 32 registers are cleared to 0.
- A write-back presented in the same cycle is discarded.
- A reset asserted mid-stream flushes the latch, so the next cycle presents a bubble.

## Timing

- Latency is one cycle: `IF_ID_*` sampled at edge N appear on `ID_EX_*` immediately after edge N.
- There is no stall or handshake; the latch loads every cycle when `rst_n`=1.
- The write-back and the ID/EX capture occur at the same edge.
- Same-cycle read and write of the same nonzero register: without bypass, the latch captures the old register value and the new value is visible from the next cycle.
- Simultaneous rs = rt = write register: both read ports behave identically.

## Configuration

- `WB_BYPASS_EN` defined: when `MEM_WB_RegWrite`=1, `MEM_WB_WriteReg`≠0, and it equals rs (or rt), the corresponding `ID_EX_readdat*` captures `MEM_WB_WriteData` instead of the stale file contents. This implements the write-first register file behaviour.
- `WB_BYPASS_EN` undefined: there is no bypass, and the read-before-write behaviour described in Timing applies.

## Structure

- Shared package `mips_pkg`:
  - opcode constants `OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`;
  - widths of the control groups (`WB_W`=2, `M_W`=3, `EX_W`=4);
  - the per-opcode control encodings.
- Sub-module `reg_file`: two asynchronous read ports, one synchronous write port, synchronous active-low clear, and the register-0 hardwire. The optional bypass lives in `i_decode`, not in `reg_file`.

## Test plan

- Reset with `rst_n`=0 for 2 cycles, then present instr 0x8C220004 → every ID/EX output is 0 during reset. Then wb=11, m=010, ex=0001, sign_ext=0x00000004, instr_2016=2.
- Write reg 1=0x55 and reg 2=0xAA via MEM_WB in two cycles, then present R-type 0x00221820 → readdat1=0x55, readdat2=0xAA, instr_1511=3, wb=10, ex=1100.
- Present beq 0x1022FFFE with npc=7 → sign_ext=0xFFFFFFFE, m=100, wb=00, ex=0010, ID_EX_npc=7.
- Write to reg 0 with data 0xDEAD, then read rs=0 → readdat1=0.
- Same-cycle write reg 5=0x1234 while rs=5, with reg 5 previously 0x11 → readdat1=0x11 without `WB_BYPASS_EN`, 0x1234 with it. The next cycle reads 0x1234 in both builds.
- Present unknown opcode 0x3F, then assert reset mid-stream after a valid lw → control groups are all 0 for the unknown opcode, and the cycle after reset shows all-zero outputs.
